uart_rx_8n1: RTL

//  Oversampling UART receiver, 8 data bits, no parity, 1 stop bit (8N1), LSB first.

---
 rtl/uart_pkg.sv | 21 ++
 rtl/baud_tick_gen.sv | 30 +++
 rtl/uart_rx_8n1.sv | 144 ++++++++++++++
 3 files changed

// File: rtl/uart_pkg.sv
// Shared definitions for the 8N1 UART receiver slice.
// FSM encodings, frame width and baud divider math.
package uart_pkg;

  localparam int DATA_BITS = 8;

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] START = 2'd1;
  localparam logic [1:0] DATA  = 2'd2;
  localparam logic [1:0] STOP  = 2'd3;

  // Clock cycles per oversample tick, rounded to nearest.
  function automatic int calc_div(
    input int clk_freq,
    input int baud,
    input int os
  );
    return (clk_freq + (baud * os) / 2) / (baud * os);
  endfunction

endpackage

// File: rtl/baud_tick_gen.sv
// Free-running divider producing one-cycle oversample ticks.
// Tick fires on the cycle the count sits at DIV-1.
module baud_tick_gen
  import uart_pkg::*;
#(
  parameter int CLK_FREQ   = 100_000_000,
  parameter int BAUD       = 9600,
  parameter int OVERSAMPLE = 16
) (
  input  logic clk,
  input  logic reset,
  output logic o_tick
);

  localparam int DIV = calc_div(CLK_FREQ, BAUD, OVERSAMPLE);
  localparam int CW  = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CW-1:0] TOP = CW'(DIV - 1);

  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;

  assign o_tick = (cnt_q == TOP);
  assign cnt_d  = o_tick ? '0 : cnt_q + CW'(1);

  always_ff @(posedge clk) begin
    if (reset) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

endmodule

// File: rtl/uart_rx_8n1.sv
// Oversampling 8N1 UART receiver, LSB first.
// Synchroniser, framing FSM, shift register and strobe outputs.
module uart_rx_8n1
  import uart_pkg::*;
#(
  parameter int CLK_FREQ   = 100_000_000,
  parameter int BAUD       = 9600,
  parameter int OVERSAMPLE = 16
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       rx,
  output logic [7:0] o_rx_data,
  output logic       o_rx_done,
  output logic       o_frame_err,
  output logic       o_busy
);

  localparam int TW = $clog2(OVERSAMPLE);
  localparam int BW = $clog2(DATA_BITS);
  localparam logic [TW-1:0] MID  = TW'(OVERSAMPLE / 2 - 1);
  localparam logic [TW-1:0] LAST = TW'(OVERSAMPLE - 1);
  localparam logic [BW-1:0] BMAX = BW'(DATA_BITS - 1);

  logic tick;

  baud_tick_gen #(
    .CLK_FREQ  (CLK_FREQ),
    .BAUD      (BAUD),
    .OVERSAMPLE(OVERSAMPLE)
  ) u_tick (
    .clk   (clk),
    .reset (reset),
    .o_tick(tick)
  );

  logic                 meta_q, rx_s_q;
  logic [1:0]           state_q, state_d;
  logic [TW-1:0]        tcnt_q, tcnt_d;
  logic [BW-1:0]        bcnt_q, bcnt_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic [7:0]           data_q, data_d;
  logic                 done_q, done_d;
  logic                 ferr_q, ferr_d;
  logic                 brk_q, brk_d;

  always_ff @(posedge clk) begin
    if (reset) begin
      meta_q <= 1'b1;
      rx_s_q <= 1'b1;
    end else begin
      meta_q <= rx;
      rx_s_q <= meta_q;
    end
  end

  always_comb begin
    state_d = state_q;
    tcnt_d  = tcnt_q;
    bcnt_d  = bcnt_q;
    shift_d = shift_q;
    data_d  = data_q;
    done_d  = 1'b0;
    ferr_d  = 1'b0;
    brk_d   = brk_q & ~rx_s_q;
    unique case (1'b1)
      (state_q == IDLE): begin
        // brk_q blocks re-arming on a line still held low after a break
        if (!rx_s_q && !brk_q) begin
          state_d = START;
          tcnt_d  = '0;
        end
      end
      (state_q == START): begin
        if (tick) begin
          if (tcnt_q == MID) begin
            tcnt_d  = '0;
            bcnt_d  = '0;
            state_d = rx_s_q ? IDLE : DATA;
          end else begin
            tcnt_d = tcnt_q + TW'(1);
          end
        end
      end
      (state_q == DATA): begin
        if (tick) begin
          if (tcnt_q == LAST) begin
            shift_d[bcnt_q] = rx_s_q;
            tcnt_d = '0;
            bcnt_d = bcnt_q + BW'(1);
            if (bcnt_q == BMAX) state_d = STOP;
          end else begin
            tcnt_d = tcnt_q + TW'(1);
          end
        end
      end
      default: begin
        if (tick) begin
          if (tcnt_q == LAST) begin
            tcnt_d  = '0;
            state_d = IDLE;
            if (rx_s_q) begin
              data_d = shift_q;
              done_d = 1'b1;
            end else begin
              ferr_d = 1'b1;
              brk_d  = 1'b1;
            end
          end else begin
            tcnt_d = tcnt_q + TW'(1);
          end
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      tcnt_q  <= '0;
      bcnt_q  <= '0;
      shift_q <= '0;
      data_q  <= '0;
      done_q  <= 1'b0;
      ferr_q  <= 1'b0;
      brk_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      tcnt_q  <= tcnt_d;
      bcnt_q  <= bcnt_d;
      shift_q <= shift_d;
      data_q  <= data_d;
      done_q  <= done_d;
      ferr_q  <= ferr_d;
      brk_q   <= brk_d;
    end
  end

  assign o_rx_data   = data_q;
  assign o_rx_done   = done_q;
  assign o_frame_err = ferr_q;
  assign o_busy      = (state_q != IDLE);

endmodule
